// File: rtl/branch_predict_resolve_unit.sv
// Branch unit: direct-mapped BTB with saturating direction counters on the fetch side,
// branch resolution, mispredict/redirect generation and table training on the execute side.
module branch_predict_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int STAT_BITS   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      if_pc,
    output logic                 if_pred_taken,
    output logic [XLEN-1:0]      if_pred_target,
    input  logic                 ex_valid,
    input  logic                 ex_branch,
    input  logic [2:0]           ex_func3,
    input  logic                 cf,
    input  logic                 zf,
    input  logic                 vf,
    input  logic                 sf,
    input  logic [XLEN-1:0]      ex_pc,
    input  logic [XLEN-1:0]      ex_target,
    input  logic                 ex_pred_taken,
    input  logic [XLEN-1:0]      ex_pred_target,
    output logic                 ex_taken,
    output logic                 mispredict,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 illegal_func3,
    output logic [STAT_BITS-1:0] stat_branches,
    output logic [STAT_BITS-1:0] stat_mispredicts
);

    localparam int IDX_BITS = $clog2(BTB_ENTRIES);
    localparam int TAG_BITS = XLEN - IDX_BITS - 2;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    logic                valid_q  [BTB_ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]     target_q [BTB_ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [BTB_ENTRIES];

    logic [STAT_BITS-1:0] stat_branches_q, stat_branches_d;
    logic [STAT_BITS-1:0] stat_mispredicts_q, stat_mispredicts_d;

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0] if_tag, ex_tag;
    logic                if_hit, ex_hit;
    logic                rb, train_en, entry_we, ctr_we;
    logic [CTR_BITS-1:0] ctr_d;

    // PC bits [1:0] are always zero for aligned instructions and never index the table.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_BITS+2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_BITS+2];

    assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign if_pred_taken  = if_hit && ctr_q[if_idx][CTR_BITS-1];
    assign if_pred_target = if_pred_taken ? target_q[if_idx] : '0;

    assign rb = ex_valid && ex_branch;

    always_comb begin
        ex_taken      = 1'b0;
        illegal_func3 = 1'b0;
        if (rb) begin
            case (ex_func3)
                3'd0:    ex_taken = zf;
                3'd1:    ex_taken = ~zf;
                3'd4:    ex_taken = sf ^ vf;
                3'd5:    ex_taken = ~(sf ^ vf);
                3'd6:    ex_taken = ~cf;
                3'd7:    ex_taken = cf;
                default: illegal_func3 = 1'b1;
            endcase
        end
    end

    // An illegal func3 resolves not-taken, so a taken prediction recovers to pc+4.
    assign mispredict = rb && ((ex_pred_taken != ex_taken) ||
                               (ex_pred_taken && ex_taken && (ex_pred_target != ex_target)));
    assign redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);

    assign train_en = rb && !illegal_func3;
    assign ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_comb begin
        ctr_d    = ctr_q[ex_idx];
        entry_we = 1'b0;
        ctr_we   = 1'b0;
        if (ex_taken) begin
            entry_we = 1'b1;
            ctr_we   = 1'b1;
            if (!ex_hit)
                ctr_d = CTR_WT;
            else if (ctr_q[ex_idx] != CTR_MAX)
                ctr_d = ctr_q[ex_idx] + CTR_BITS'(1);
        end else if (ex_hit) begin
            ctr_we = 1'b1;
            if (ctr_q[ex_idx] != '0)
                ctr_d = ctr_q[ex_idx] - CTR_BITS'(1);
        end
    end

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (train_en && (stat_branches_q != '1))
            stat_branches_d = stat_branches_q + STAT_BITS'(1);
        if (mispredict && (stat_mispredicts_q != '1))
            stat_mispredicts_d = stat_mispredicts_q + STAT_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (train_en && entry_we) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
            end
            if (train_en && ctr_we)
                ctr_q[ex_idx] <= ctr_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// Directed bench for branch_predict_resolve_unit: each task drives one scenario and
// checks outputs against hand-computed values; expected stats tracked in exp_br/exp_mp.
module tb_branch_predict_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid, ex_branch;
    logic [2:0]  ex_func3;
    logic        cf, zf, vf, sf;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        ex_pred_taken;
    logic        ex_taken, mispredict, illegal_func3;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches, stat_mispredicts;

    int checks   = 0;
    int failures = 0;
    int exp_br   = 0;
    int exp_mp   = 0;

    always #5 clk = ~clk;

    branch_predict_resolve_unit dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_func3(ex_func3),
        .cf(cf), .zf(zf), .vf(vf), .sf(sf),
        .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_taken(ex_taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .illegal_func3(illegal_func3),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ex_valid = 1'b0; ex_branch = 1'b0; ex_func3 = 3'd0;
        cf = 1'b0; zf = 1'b0; vf = 1'b0; sf = 1'b0;
        ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    endtask

    task automatic drive_br(input logic [2:0] f3, input logic z, input logic [31:0] pc,
                            input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_branch = 1'b1; ex_func3 = f3;
        zf = z; sf = 1'b0; vf = 1'b0; cf = 1'b0;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1; if_pc = 32'h100;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred_taken got=%0b exp=0", if_pred_taken); end
        checks++; if (if_pred_target !== 32'h0) begin failures++; $display("FAIL reset_pred_target got=%h exp=0", if_pred_target); end
        checks++; if (stat_branches !== 32'd0) begin failures++; $display("FAIL reset_stat_br got=%0d exp=0", stat_branches); end
        checks++; if (stat_mispredicts !== 32'd0) begin failures++; $display("FAIL reset_stat_mp got=%0d exp=0", stat_mispredicts); end
    endtask

    task automatic test_func3();
        logic [7:0] exp_tk;
        exp_tk = 8'b0101_0001; // bit f: taken for flags z=1,s=1,v=0,c=0
        for (int f = 0; f < 8; f++) begin
            drive_br(3'(f), 1'b1, 32'h208, 32'h300, 1'b0, 32'h0);
            sf = 1'b1;
            #1;
            checks++; if (ex_taken !== exp_tk[f]) begin failures++; $display("FAIL func3_taken f=%0d got=%0b exp=%0b", f, ex_taken, exp_tk[f]); end
            checks++; if (illegal_func3 !== (f == 2 || f == 3)) begin failures++; $display("FAIL func3_illegal f=%0d got=%0b", f, illegal_func3); end
            if (!(f == 2 || f == 3)) exp_br++;
            if (exp_tk[f]) exp_mp++;
            tick();
            checks++; if (stat_branches !== 32'(exp_br)) begin failures++; $display("FAIL func3_stat_br f=%0d got=%0d exp=%0d", f, stat_branches, exp_br); end
        end
        checks++; if (stat_mispredicts !== 32'(exp_mp)) begin failures++; $display("FAIL func3_stat_mp got=%0d exp=%0d", stat_mispredicts, exp_mp); end
        drive_idle();
    endtask

    task automatic test_training();
        if_pc = 32'h100;
        for (int c = 0; c < 3; c++) begin
            drive_br(3'd0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);
            #1;
            checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL train_mp c=%0d got=%0b exp=1", c, mispredict); end
            checks++; if (redirect_pc !== 32'h80) begin failures++; $display("FAIL train_redirect c=%0d got=%h exp=80", c, redirect_pc); end
            checks++; if (if_pred_taken !== (c != 0)) begin failures++; $display("FAIL train_lookup c=%0d got=%0b exp=%0b", c, if_pred_taken, c != 0); end
            exp_br++; exp_mp++;
            tick();
        end
        checks++; if (if_pred_target !== 32'h80) begin failures++; $display("FAIL train_target got=%h exp=80", if_pred_target); end
        // Counter at 11: first not-taken leaves it at 10 (still taken), second at 01.
        for (int c = 0; c < 2; c++) begin
            drive_br(3'd0, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
            #1;
            checks++; if (redirect_pc !== 32'h104) begin failures++; $display("FAIL nt_redirect c=%0d got=%h exp=104", c, redirect_pc); end
            exp_br++; exp_mp++;
            tick();
            checks++; if (if_pred_taken !== (c == 0)) begin failures++; $display("FAIL nt_lookup c=%0d got=%0b exp=%0b", c, if_pred_taken, c == 0); end
        end
        checks++; if (if_pred_target !== 32'h0) begin failures++; $display("FAIL nt_target got=%h exp=0", if_pred_target); end
        drive_idle();
    endtask

    task automatic test_target_mismatch();
        if_pc = 32'h100;
        drive_br(3'd0, 1'b1, 32'h100, 32'h90, 1'b1, 32'h80);
        #1;
        checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL tgt_mp got=%0b exp=1", mispredict); end
        checks++; if (redirect_pc !== 32'h90) begin failures++; $display("FAIL tgt_redirect got=%h exp=90", redirect_pc); end
        exp_br++; exp_mp++;
        tick();
        checks++; if (if_pred_target !== 32'h90) begin failures++; $display("FAIL tgt_update got=%h exp=90", if_pred_target); end
        drive_br(3'd0, 1'b1, 32'h100, 32'h90, 1'b1, 32'h90);
        #1;
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL tgt_correct_mp got=%0b exp=0", mispredict); end
        exp_br++;
        tick();
        drive_idle();
        checks++; if (stat_mispredicts !== 32'(exp_mp)) begin failures++; $display("FAIL tgt_stat_mp got=%0d exp=%0d", stat_mispredicts, exp_mp); end
    endtask

    task automatic test_wrap();
        drive_br(3'd1, 1'b1, 32'hFFFF_FFFC, 32'h40, 1'b1, 32'h40);
        #1;
        checks++; if (ex_taken !== 1'b0) begin failures++; $display("FAIL wrap_taken got=%0b exp=0", ex_taken); end
        checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL wrap_mp got=%0b exp=1", mispredict); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL wrap_redirect got=%h exp=0", redirect_pc); end
        exp_br++; exp_mp++;
        tick();
        drive_idle();
    endtask

    task automatic test_illegal_pred();
        drive_br(3'd3, 1'b1, 32'h20, 32'h60, 1'b1, 32'h60);
        #1;
        checks++; if (illegal_func3 !== 1'b1) begin failures++; $display("FAIL illp_illegal got=%0b exp=1", illegal_func3); end
        checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL illp_mp got=%0b exp=1", mispredict); end
        checks++; if (redirect_pc !== 32'h24) begin failures++; $display("FAIL illp_redirect got=%h exp=24", redirect_pc); end
        exp_mp++;
        tick();
        drive_idle();
        checks++; if (stat_branches !== 32'(exp_br)) begin failures++; $display("FAIL illp_stat_br got=%0d exp=%0d", stat_branches, exp_br); end
        checks++; if (stat_mispredicts !== 32'(exp_mp)) begin failures++; $display("FAIL illp_stat_mp got=%0d exp=%0d", stat_mispredicts, exp_mp); end
    endtask

    task automatic test_gating();
        drive_br(3'd0, 1'b1, 32'h300, 32'h44, 1'b0, 32'h0);
        ex_valid = 1'b0;
        if_pc = 32'h300;
        #1;
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL gate_mp got=%0b exp=0", mispredict); end
        checks++; if (ex_taken !== 1'b0) begin failures++; $display("FAIL gate_taken got=%0b exp=0", ex_taken); end
        tick();
        drive_idle();
        #1;
        checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL gate_lookup got=%0b exp=0", if_pred_taken); end
        if_pc = 32'h100;
        #1;
        checks++; if (if_pred_target !== 32'h90) begin failures++; $display("FAIL gate_entry0 got=%h exp=90", if_pred_target); end
        checks++; if (stat_branches !== 32'(exp_br)) begin failures++; $display("FAIL gate_stat_br got=%0d exp=%0d", stat_branches, exp_br); end
        checks++; if (stat_mispredicts !== 32'(exp_mp)) begin failures++; $display("FAIL gate_stat_mp got=%0d exp=%0d", stat_mispredicts, exp_mp); end
    endtask

    task automatic test_back_to_back();
        if_pc = 32'h14;
        drive_br(3'd0, 1'b1, 32'h14, 32'h50, 1'b0, 32'h0);
        exp_br++; exp_mp++;
        tick();
        // Same-cycle update and lookup of index 5: lookup still sees counter 10.
        drive_br(3'd0, 1'b0, 32'h14, 32'h50, 1'b1, 32'h50);
        #1;
        checks++; if (if_pred_taken !== 1'b1) begin failures++; $display("FAIL rbw_old_taken got=%0b exp=1", if_pred_taken); end
        checks++; if (if_pred_target !== 32'h50) begin failures++; $display("FAIL rbw_old_target got=%h exp=50", if_pred_target); end
        exp_br++; exp_mp++;
        tick();
        drive_idle();
        #1;
        checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL rbw_new_taken got=%0b exp=0", if_pred_taken); end
        checks++; if (stat_branches !== 32'(exp_br)) begin failures++; $display("FAIL rbw_stat_br got=%0d exp=%0d", stat_branches, exp_br); end
        checks++; if (stat_mispredicts !== 32'(exp_mp)) begin failures++; $display("FAIL rbw_stat_mp got=%0d exp=%0d", stat_mispredicts, exp_mp); end
    endtask

    task automatic test_reset_drop();
        drive_br(3'd0, 1'b1, 32'h18, 32'h70, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_idle();
        exp_br = 0; exp_mp = 0;
        if_pc = 32'h18;
        #1;
        checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL rstdrop_lookup got=%0b exp=0", if_pred_taken); end
        if_pc = 32'h100;
        #1;
        checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL rstdrop_cleared got=%0b exp=0", if_pred_taken); end
        checks++; if (stat_branches !== 32'(exp_br)) begin failures++; $display("FAIL rstdrop_stat_br got=%0d exp=0", stat_branches); end
        checks++; if (stat_mispredicts !== 32'(exp_mp)) begin failures++; $display("FAIL rstdrop_stat_mp got=%0d exp=0", stat_mispredicts); end
    endtask

    initial begin
        rst = 1'b1;
        if_pc = '0;
        drive_idle();
        tick();
        test_reset();
        test_func3();
        test_training();
        test_target_mismatch();
        test_wrap();
        test_illegal_pred();
        test_gating();
        test_back_to_back();
        test_reset_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
